// File: rtl/intra_edge_upsampler_pkg.sv
// Shared types and constants for the AV1 intra edge upsampler.
//   ieu_state_t       : controller state encoding (IDLE, LOAD, EMIT)
//   UPSAMPLE_MAX_D    : |delta| at or above which upsampling is never used
//   BLKWH_LIM_*       : w+h ceilings for smooth / sharp neighbour filtering
//   select_upsample() : AV1 useUpsample decision for one block
package intra_edge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } ieu_state_t;

    localparam int UPSAMPLE_MAX_D   = 40;
    localparam int BLKWH_LIM_SMOOTH = 8;
    localparam int BLKWH_LIM_SHARP  = 16;

    function automatic logic select_upsample(
        input logic [9:0]        w,
        input logic [9:0]        h,
        input logic              filter_type,
        input logic signed [9:0] delta,
        input logic              num_px_zero
    );
        logic signed [10:0] delta_x;
        logic        [10:0] d;
        logic        [10:0] blk_wh;
        logic        [10:0] lim;
        delta_x = {delta[9], delta};
        d       = delta_x[10] ? -delta_x : delta_x;
        blk_wh  = {1'b0, w} + {1'b0, h};
        lim     = filter_type ? 11'(BLKWH_LIM_SMOOTH) : 11'(BLKWH_LIM_SHARP);
        if (num_px_zero || (d == 11'd0) || (d >= 11'(UPSAMPLE_MAX_D))) begin
            return 1'b0;
        end
        return (blk_wh <= lim);
    endfunction

endpackage

// File: rtl/intra_edge_upsampler_if.sv
// Block descriptor, sample-in and sample-out bundle of the intra edge upsampler.
//   master : edge fetch / predictor side (drives descriptor, in samples, out_ready)
//   slave  : the upsampler itself
interface intra_edge_upsampler_if #(
    parameter int BIT_DEPTH = 10,
    parameter int MAX_PX    = 16
);
    localparam int NPW = $clog2(MAX_PX + 1);

    logic                  start;
    logic [9:0]            w;
    logic [9:0]            h;
    logic                  filter_type;
    logic signed [9:0]     delta;
    logic [NPW-1:0]        num_px;
    logic                  busy;
    logic                  use_upsample;
    logic                  in_valid;
    logic                  in_ready;
    logic [BIT_DEPTH-1:0]  in_sample;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIT_DEPTH-1:0]  out_sample;
    logic                  out_last;

    modport master (
        output start, w, h, filter_type, delta, num_px,
        output in_valid, in_sample, out_ready,
        input  busy, use_upsample, in_ready, out_valid, out_sample, out_last
    );

    modport slave (
        input  start, w, h, filter_type, delta, num_px,
        input  in_valid, in_sample, out_ready,
        output busy, use_upsample, in_ready, out_valid, out_sample, out_last
    );

endinterface

// File: rtl/intra_edge_upsampler_tap.sv
// Combinational AV1 upsample tap: (-p0 + 9*p1 + 9*p2 - p3 + 8) >>> 4,
// clipped to [0, 2^BIT_DEPTH-1].
//   p0..p3 : four consecutive edge samples
//   r      : interpolated sample between p1 and p2
module intra_edge_upsample_tap #(
    parameter int BIT_DEPTH = 10
) (
    input  logic [BIT_DEPTH-1:0] p0,
    input  logic [BIT_DEPTH-1:0] p1,
    input  logic [BIT_DEPTH-1:0] p2,
    input  logic [BIT_DEPTH-1:0] p3,
    output logic [BIT_DEPTH-1:0] r
);
    // 18*max sample plus rounding fits in BIT_DEPTH+6 signed bits
    localparam int SW = BIT_DEPTH + 6;
    localparam logic signed [SW-1:0] RND  = SW'(8);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << BIT_DEPTH) - 1);

    logic signed [SW-1:0] e0, e1, e2, e3, inner, s, q;

    always_comb begin
        e0    = $signed(SW'(p0));
        e1    = $signed(SW'(p1));
        e2    = $signed(SW'(p2));
        e3    = $signed(SW'(p3));
        inner = e1 + e2;
        s     = (inner <<< 3) + inner - e0 - e3;
        q     = (s + RND) >>> 4;
        if (q[SW-1]) begin
            r = '0;
        end else if (q > MAXV) begin
            r = '1;
        end else begin
            r = q[BIT_DEPTH-1:0];
        end
    end

endmodule

// File: rtl/intra_edge_upsampler.sv
// AV1 intra edge upsampler. Accepts a block descriptor, decides useUpsample,
// buffers num_px+1 edge samples (buf[-1] first) and streams either the
// 2*num_px+1 upsampled edge or the unchanged num_px+1 samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : descriptor (start/w/h/filter_type/delta/num_px), busy,
//                use_upsample, input stream (in_*), output stream (out_*)
//
// state | meaning
// IDLE  | waiting for start; descriptor latched and selection made on start
// LOAD  | accepting num_px+1 samples into the buffer
// EMIT  | streaming the edge through the registered output stage
module intra_edge_upsampler
    import intra_edge_pkg::*;
#(
    parameter int BIT_DEPTH = 10,
    parameter int MAX_PX    = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    intra_edge_upsampler_if.slave  bus
);
    localparam int NPW = $clog2(MAX_PX + 1);
    localparam int OCW = NPW + 1;

    ieu_state_t state_q, state_d;

    logic [NPW-1:0]       num_px_q, num_px_clamped, in_cnt_q;
    logic [OCW-1:0]       out_cnt_q, last_idx;
    logic                 use_q;
    logic [BIT_DEPTH-1:0] mem [0:MAX_PX];
    logic                 out_valid_q, out_last_q;
    logic [BIT_DEPTH-1:0] out_sample_q;

    logic                 start_acc, in_ready, in_hs, load_out, emit_done;
    logic [NPW-1:0]       m_idx, idx_a, idx_c, idx_d;
    logic [NPW:0]         m_plus2;
    logic [BIT_DEPTH-1:0] tap_r, emit_sample;

    assign num_px_clamped = (bus.num_px > NPW'(MAX_PX)) ? NPW'(MAX_PX) : bus.num_px;
    assign in_hs          = in_ready & bus.in_valid;
    assign last_idx       = use_q ? {num_px_q, 1'b0} : {1'b0, num_px_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        in_ready  = 1'b0;
        load_out  = 1'b0;
        emit_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid && (in_cnt_q == num_px_q)) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_valid_q && bus.out_ready && out_last_q) begin
                    emit_done = 1'b1;
                    state_d   = IDLE;
                end else if (!out_valid_q || bus.out_ready) begin
                    load_out = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_px_q     <= '0;
            use_q        <= 1'b0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_sample_q <= '0;
        end else begin
            if (start_acc) begin
                num_px_q  <= num_px_clamped;
                use_q     <= select_upsample(bus.w, bus.h, bus.filter_type, bus.delta,
                                             (bus.num_px == '0));
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end
            if (in_hs) begin
                in_cnt_q <= in_cnt_q + 1'b1;
            end
            if (load_out) begin
                out_valid_q  <= 1'b1;
                out_sample_q <= emit_sample;
                out_last_q   <= (out_cnt_q == last_idx);
                out_cnt_q    <= out_cnt_q + 1'b1;
            end else if (emit_done) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    // Buffer carries no reset: every entry read in EMIT was written in LOAD.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            mem[in_cnt_q] <= bus.in_sample;
        end
    end

    // mem[j] holds buf[j-1]. Output pair m is (buf[m-1], r_m); the tap window
    // for r_m is buf[m-2..m+1] with both ends clamped to the stored edge.
    always_comb begin
        m_idx   = out_cnt_q[OCW-1:1];
        idx_a   = (m_idx == '0) ? '0 : m_idx - 1'b1;
        idx_c   = m_idx + 1'b1;
        m_plus2 = {1'b0, m_idx} + (NPW+1)'(2);
        idx_d   = (m_plus2 > {1'b0, num_px_q}) ? num_px_q : m_plus2[NPW-1:0];
    end

    intra_edge_upsample_tap #(.BIT_DEPTH(BIT_DEPTH)) u_tap (
        .p0 (mem[idx_a]),
        .p1 (mem[m_idx]),
        .p2 (mem[idx_c]),
        .p3 (mem[idx_d]),
        .r  (tap_r)
    );

    always_comb begin
        emit_sample = '0;
        if (!use_q) begin
            emit_sample = mem[out_cnt_q[NPW-1:0]];
        end else if (out_cnt_q[0]) begin
            emit_sample = tap_r;
        end else begin
            emit_sample = mem[m_idx];
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.use_upsample = use_q;
    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sample   = out_sample_q;
    assign bus.out_last     = out_last_q;

endmodule
